// File: rtl/aes_sbox_scheduler.sv
// Purpose: shares four byte S-Boxes between SubBytes (4 beats) and SubWord (1 beat) requests.
// Latency: key result 2 cycles after accept, data result 5 cycles after accept (+1 per interleaved key slot).
// Backpressure: one request buffered per requester (ready low while held); outputs are pulse-only, no stall.

// Single AES S-Box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] m, input logic [7:0] n);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = m;
        for (int i = 0; i < 8; i++) begin
            if (n[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128 gives the inverse (and maps 0 to 0), then affine map
    always_comb begin
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module aes_sbox_scheduler (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iData_Valid,
    output logic         oData_Ready,
    input  logic [127:0] iData_In,
    output logic         oData_Valid,
    output logic [127:0] oData_Out,
    input  logic         iKey_Valid,
    output logic         oKey_Ready,
    input  logic [31:0]  iKey_Word,
    output logic         oKey_Valid,
    output logic [31:0]  oKey_Out
);

    logic         data_busy;
    logic [1:0]   beat_cnt;
    logic [127:0] data_buf;
    logic [127:0] res_buf;
    logic         key_pend;
    logic [31:0]  key_buf;
    logic         last_key;

    logic         data_hs;
    logic         key_hs;
    logic         grant_key;
    logic         grant_data;
    logic [31:0]  data_slice;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [127:0] res_next;

    assign oData_Ready = ~data_busy;
    assign oKey_Ready  = ~key_pend;
    assign data_hs     = iData_Valid & ~data_busy;
    assign key_hs      = iKey_Valid & ~key_pend;

    // Key wins the slot unless it had the previous slot while a block is in flight
    assign grant_key  = key_pend & (~data_busy | ~last_key);
    assign grant_data = ~grant_key & data_busy;

    // Select the current data beat and merge the S-Box result into the result buffer
    always_comb begin
        data_slice = data_buf[127:96];
        res_next   = res_buf;
        case (beat_cnt)
            2'd0: begin data_slice = data_buf[127:96]; res_next[127:96] = sbox_out; end
            2'd1: begin data_slice = data_buf[95:64];  res_next[95:64]  = sbox_out; end
            2'd2: begin data_slice = data_buf[63:32];  res_next[63:32]  = sbox_out; end
            default: begin data_slice = data_buf[31:0]; res_next[31:0] = sbox_out; end
        endcase
    end

    assign sbox_in = grant_key ? key_buf : data_slice;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (
                .a (sbox_in[8*g +: 8]),
                .y (sbox_out[8*g +: 8])
            );
        end
    endgenerate

    // Key request buffer, result register and single-cycle valid pulse
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            key_pend   <= 1'b0;
            key_buf    <= 32'h0;
            oKey_Valid <= 1'b0;
            oKey_Out   <= 32'h0;
            last_key   <= 1'b0;
        end else begin
            oKey_Valid <= 1'b0;
            last_key   <= grant_key;
            if (key_hs) begin
                key_buf  <= iKey_Word;
                key_pend <= 1'b1;
            end else if (grant_key) begin
                key_pend   <= 1'b0;
                oKey_Valid <= 1'b1;
                oKey_Out   <= sbox_out;
            end
        end
    end

    // Data request buffer, beat sequencing and block result with single-cycle valid pulse
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            data_busy   <= 1'b0;
            beat_cnt    <= 2'd0;
            data_buf    <= 128'h0;
            res_buf     <= 128'h0;
            oData_Valid <= 1'b0;
            oData_Out   <= 128'h0;
        end else begin
            oData_Valid <= 1'b0;
            if (data_hs) begin
                data_buf  <= iData_In;
                data_busy <= 1'b1;
                beat_cnt  <= 2'd0;
            end else if (grant_data) begin
                res_buf  <= res_next;
                beat_cnt <= beat_cnt + 2'd1;
                if (beat_cnt == 2'd3) begin
                    data_busy   <= 1'b0;
                    oData_Valid <= 1'b1;
                    oData_Out   <= res_next;
                end
            end
        end
    end

endmodule

// File: doc/aes_sbox_scheduler.md
# aes_sbox_scheduler

Time-shares one bank of four byte S-Box instances (32 bits per cycle) between two requesters in the AES-128 core: the round datapath (SubBytes on the 128-bit state, four beats) and the key expansion unit (SubWord on one 32-bit word, one beat). The block buffers each request, arbitrates the shared S-Box slot cycle by cycle, and returns registered results with single-cycle valid pulses. It sits between the round controller / key expansion and the S-Box bank, replacing sixteen-plus-four dedicated S-Boxes with four.

## Interface
- No parameters. Width is fixed: 128-bit state, 32-bit word, 4 S-Box instances.
- iClk  in  1  clock, rising edge
- iRsn  in  1  reset, asynchronous, active-low
- iData_Valid  in  1  SubBytes request valid
- oData_Ready  out  1  SubBytes request can be accepted
- iData_In  in  128  state; byte i at bits [127-8i -: 8]
- oData_Valid  out  1  one-cycle pulse: oData_Out valid
- oData_Out  out  128  SubBytes result, same byte order, held until next result
- iKey_Valid  in  1  SubWord request valid
- oKey_Ready  out  1  SubWord request can be accepted
- iKey_Word  in  32  word to substitute
- oKey_Valid  out  1  one-cycle pulse: oKey_Out valid
- oKey_Out  out  32  SubWord result, held until next result

## Operation
- Internal state: data_busy, beat_cnt[1:0], data_buf[127:0], res_buf[127:0], key_pend, key_buf[31:0], last_key.
- oData_Ready = ~data_busy; oKey_Ready = ~key_pend (combinational from registers only; no input-to-output paths).
- Data handshake (iData_Valid & oData_Ready): data_buf <= iData_In, data_busy <= 1, beat_cnt <= 0.
- Key handshake (iKey_Valid & oKey_Ready): key_buf <= iKey_Word, key_pend <= 1.
- A request accepted in cycle N competes for the slot from cycle N+1.
- Slot grant each cycle:
  - KEY if key_pend & (~data_busy | ~last_key)
  - else DATA if data_busy
  - else IDLE
- KEY grant: S-Box inputs = key_buf; oKey_Out <= result; oKey_Valid <= 1; key_pend <= 0; last_key <= 1.
- DATA grant: S-Box inputs = data_buf[127-32k -: 32] for k = beat_cnt; res_buf at the same slice <= result; beat_cnt++; last_key <= 0. On beat 3: data_busy <= 0, oData_Valid <= 1, oData_Out <= res_buf with slice 3 merged.
- IDLE: last_key <= 0.
- Key has priority but cannot take two consecutive slots while data is pending; data is never starved.
- No back-pressure on outputs: consumers must take results on the valid pulse.

## Timing
- Reset values: oData_Valid = 0, oKey_Valid = 0, oData_Out = 0, oKey_Out = 0, oData_Ready = 1, oKey_Ready = 1. All internal registers reset to 0.
- Key latency: accepted in cycle N, oKey_Valid in N+2 when uncontended.
- Data latency: accepted in cycle N, beats in N+1..N+4, oData_Valid in N+5. Each interleaved key slot adds 1 cycle.
- Throughput:
  - Data: one block per 5 cycles. oData_Ready rises in the cycle oData_Valid pulses, so a new block may be accepted in that same cycle.
  - Key: one word per 2 cycles.
- Simultaneous data and key handshakes in one cycle: both accepted. Next cycle grants KEY.
- Key arrives mid-block: takes the next slot, and beat_cnt holds for that cycle.
- Continuous key stream during a block: slots alternate KEY/DATA; the block completes in at most 8 slots.
- Reset asserted mid-operation: all state clears immediately. Pending requests are dropped and no valid pulse is produced.
- oData_Out and oKey_Out change only on their valid pulses.

## Test plan
- Reset, then idle: oData_Ready = oKey_Ready = 1, both valids 0, both outputs 0.
- Data only: iData_In = 00102030405060708090a0b0c0d0e0f0 accepted at N -> oData_Valid at N+5 with oData_Out = 63cab7040953d051cd60e0e7ba70e18c; oData_Ready low N+1..N+4.
- Key only: iKey_Word = cf4f3c09 at N -> oKey_Valid at N+2, oKey_Out = 8a84eb01. Back-to-back: 00000000 accepted at N+2 -> 63636363 at N+4.
- Simultaneous accept at N of the data vector above and key word 53535353 -> oKey_Valid at N+2 with edededed; oData_Valid at N+6 with the correct block.
- Key held valid continuously during a data block: grants alternate KEY/DATA (no two consecutive KEY slots while data_busy); data result is correct; every key result equals SubWord of its input.
- iRsn pulsed low at N+2 of a data block: outputs return to reset values, no oData_Valid pulse. A new request after release completes normally.
